// File: rtl/alimentador_anillo_pkg.sv
// Shared constants and FSM encoding for the systolic ring feeder.
// Default element width and ring length match the unidad ring ports.
// State encoding is shared so a bench or wrapper can decode it if needed.
package alimentador_anillo_pkg;

  localparam int W_DEF = 16;
  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alimentador_anillo_banco_matriz.sv
// NxN register file holding the coefficient matrix, one write port.
// Latency: write visible the cycle after the strobe; reads are combinational.
// No backpressure: the owner gates the write strobe (frozen while a run is live).
module alimentador_anillo_banco_matriz #(
  parameter  int W  = 16,
  parameter  int N  = 4,
  localparam int LN = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we_i,
  input  logic [LN-1:0]   wr_row_i,
  input  logic [LN-1:0]   wr_col_i,
  input  logic [W-1:0]    wr_dat_i,
  input  logic [LN-1:0]   rd_k_i,
  output logic [N*W-1:0]  rd_dat_o
);

  logic [W-1:0] mem_q [N][N];

  // Storage: cleared on reset, single element written per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_dat_i;
    end
  end

  // Row r reads column (r - k) mod N; N is a power of two so the
  // log2N-bit subtraction wraps exactly as the diagonal skew needs.
  for (genvar r = 0; r < N; r++) begin : g_rd
    logic [LN-1:0] col;
    assign col = LN'(r) - rd_k_i;
    assign rd_dat_o[r*W +: W] = mem_q[r][col];
  end

endmodule

// File: rtl/alimentador_anillo.sv
// Feeds the systolic ring: holds A and x, pulses ring reset, streams N skewed diagonals.
// Latency: start in cycle t -> LOAD t+1, RUN t+2..t+N+1, done pulse in cycle t+N+2.
// No backpressure: host writes and start are only honoured in IDLE, otherwise dropped.
module alimentador_anillo
  import alimentador_anillo_pkg::*;
#(
  parameter  int W  = W_DEF,
  parameter  int N  = N_DEF,
  localparam int LN = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_vec,
  input  logic [LN-1:0]   wr_row,
  input  logic [LN-1:0]   wr_col,
  input  logic [W-1:0]    wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            ring_reset,
  output logic [N*W-1:0]  x_out,
  output logic [N*W-1:0]  a_out,
  output logic            step_valid,
  output logic [LN-1:0]   step_idx
);

  state_e              state_q, state_d;
  logic [LN-1:0]       cnt_q, cnt_d;
  logic [N-1:0][W-1:0] x_q;
  logic                busy_q, done_q, ring_reset_q, step_valid_q;
  logic [N*W-1:0]      a_out_q;
  logic [N*W-1:0]      diag_dat;
  logic                wr_ok;

  assign wr_ok = wr_en && (state_q == ST_IDLE);

  alimentador_anillo_banco_matriz #(.W(W), .N(N)) u_banco (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wr_ok && !wr_vec),
    .wr_row_i (wr_row),
    .wr_col_i (wr_col),
    .wr_dat_i (wr_data),
    .rd_k_i   (cnt_d),
    .rd_dat_o (diag_dat)
  );

  // State and diagonal counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter is zero outside RUN so step k=0 follows LOAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        cnt_d = cnt_q + LN'(1);
        if (cnt_q == LN'(N - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Vector registers: written only in IDLE, exposed directly on x_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
    end else if (wr_ok && wr_vec) begin
      x_q[wr_row] <= wr_data;
    end
  end

  // Registered outputs decoded from the state being entered, so each
  // output lines up with its state; ring_reset is held high during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ring_reset_q <= 1'b1;
      step_valid_q <= 1'b0;
      a_out_q      <= '0;
    end else begin
      busy_q       <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_q       <= (state_d == ST_DONE);
      ring_reset_q <= (state_d == ST_LOAD);
      step_valid_q <= (state_d == ST_RUN);
      a_out_q      <= (state_d == ST_RUN) ? diag_dat : '0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ring_reset = ring_reset_q;
  assign step_valid = step_valid_q;
  assign step_idx   = cnt_q;
  assign a_out      = a_out_q;
  assign x_out      = x_q;

endmodule
